// File: rtl/md_unit_pkg.sv
// Shared types and arithmetic for the multiply/divide unit.
// The full HI/LO result is computed when operands are latched; the busy window only models latency.
package md_unit_pkg;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5
  } md_op_e;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } md_state_e;

  localparam int CNT_W = 16;

  typedef struct packed {
    logic        wr;
    logic [31:0] hi;
    logic [31:0] lo;
  } md_result_t;

  function automatic logic is_long_op(logic [2:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic is_mult_op(logic [2:0] op);
    return (op == MD_MULT) || (op == MD_MULTU);
  endfunction

  // A cleared wr bit means the operation completes without touching HI/LO (divide by zero).
  function automatic md_result_t md_compute(logic [2:0] op, logic [31:0] a, logic [31:0] b);
    md_result_t        r;
    logic signed [63:0] pa;
    logic signed [63:0] pb;
    logic [63:0]        prod;
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    r    = '0;
    pa   = {{32{a[31]}}, a};
    pb   = {{32{b[31]}}, b};
    prod = '0;
    sa   = a;
    sb   = b;
    case (op)
      MD_MULT: begin
        prod = pa * pb;
        r    = {1'b1, prod[63:32], prod[31:0]};
      end
      MD_MULTU: begin
        prod = {32'd0, a} * {32'd0, b};
        r    = {1'b1, prod[63:32], prod[31:0]};
      end
      MD_DIV: begin
        // The one overflowing quotient is pinned explicitly rather than left to the simulator.
        if (b == 32'd0) begin
          r.wr = 1'b0;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          r = {1'b1, 32'd0, 32'h8000_0000};
        end else begin
          r.wr = 1'b1;
          r.lo = sa / sb;
          r.hi = sa % sb;
        end
      end
      MD_DIVU: begin
        if (b == 32'd0) begin
          r.wr = 1'b0;
        end else begin
          r = {1'b1, a % b, a / b};
        end
      end
      default: r.wr = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit owning the HI/LO pair.
// Holds busy for MULT_CYCLES or DIV_CYCLES, then commits the precomputed result in one edge.
module md_unit
  import md_unit_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] rsdata,
  input  logic [31:0] rtdata,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  md_state_e        state;
  md_state_e        next_state;
  logic [CNT_W-1:0] counter;
  md_result_t       result;
  logic             accept;
  logic             last_cycle;

  assign accept     = start && (state == IDLE) && is_long_op(md_op);
  assign last_cycle = (state == RUN) && (counter <= CNT_W'(1));

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept) next_state = RUN;
      RUN:     if (last_cycle) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == RUN);
  end

  // mthi/mtlo only land while idle; a start during RUN is dropped entirely.
  always_ff @(posedge clk) begin
    if (reset) begin
      counter <= '0;
      result  <= '0;
      hi      <= '0;
      lo      <= '0;
    end else if (state == IDLE) begin
      if (start) begin
        if (md_op == MD_MTHI) hi <= rsdata;
        if (md_op == MD_MTLO) lo <= rsdata;
        if (is_long_op(md_op)) begin
          counter <= is_mult_op(md_op) ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
          result  <= md_compute(md_op, rsdata, rtdata);
        end
      end
    end else begin
      counter <= (counter == '0) ? '0 : counter - CNT_W'(1);
      if (last_cycle && result.wr) begin
        hi <= result.hi;
        lo <= result.lo;
      end
    end
  end

endmodule

// File: doc/md_unit.md
# md_unit

Multi-cycle multiply/divide unit for the MIPS core. It services the mult/div class of R-type instructions and drives the HI/LO pair; the single-cycle ALU does not handle these. It takes the same rsdata/rtdata operands the ALU receives. It holds a busy window so the controller can stall any following md instruction or mfhi/mflo. mfhi/mflo read the hi/lo outputs directly.

## Interface
Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (≥1)
- DIV_CYCLES, 10, busy cycles for div/divu (≥1)

Ports:
- clk  in  1  core clock; all state changes on rising edge
- reset  in  1  synchronous, active-high; one clock, reset is synchronous and active-high
- start  in  1  issue strobe, single-cycle pulse per instruction
- md_op  in  3  operation: `md_mult`=0, `md_multu`=1, `md_div`=2, `md_divu`=3, `md_mthi`=4, `md_mtlo`=5; 6/7 illegal
- rsdata  in  32  operand A / mthi-mtlo source
- rtdata  in  32  operand B
- busy  out  1  operation in flight
- hi  out  32  HI register
- lo  out  32  LO register

## Operation
- State: IDLE, RUN. Internal: counter (≥4 bits), latched op, latched result pair.
- Reset: state=IDLE, busy=0, hi=0, lo=0, counter=0; any in-flight result discarded.
- IDLE, start=1, op mult/multu/div/divu:
  - latch operands and op; load counter with MULT_CYCLES or DIV_CYCLES; go to RUN.
- IDLE, start=1, mthi/mtlo:
  - write rsdata to hi/lo at that edge; stay in IDLE; busy stays 0.
- start with md_op 6/7: ignored.
- RUN: counter decrements each edge. At the edge where it goes 1→0:
  - write HI/LO, return to IDLE.
- start while busy=1: ignored entirely, including mthi/mtlo. The controller must stall; the unit does not queue.
- Arithmetic on latched operands:
  - mult: signed 32×32→64, hi=[63:32], lo=[31:0].
  - multu: same, unsigned.
  - div: lo=signed quotient truncated toward zero, hi=remainder with the sign of the dividend.
  - divu: unsigned quotient/remainder.
  - div 0x80000000/0xFFFFFFFF: lo=0x80000000, hi=0.
- Divide by zero (rtdata=0, div or divu): full busy window runs; hi/lo unchanged.
- hi/lo hold their old values throughout RUN; only the final edge updates them.
- The result may be computed at latch time or iteratively. Only the timing below is observable.

## Timing
- Issue edge t0 (start=1, busy=0): busy=1 from t0 through edge t0+L, where L=MULT_CYCLES or DIV_CYCLES.
- busy=1 for exactly L cycles.
- New hi/lo visible immediately after edge t0+L; busy=0 in the same cycle.
- A new start is accepted at edge t0+L+1 at the earliest; back-to-back spacing is L+1 cycles.
- mthi/mtlo: hi/lo updated after edge t0; 1-cycle latency; no busy.
- reset=1 during RUN: reset values take effect at that edge; no HI/LO write that cycle.
- reset and start in the same cycle: reset wins.
- Operands only need to be valid in the start cycle; later changes to rsdata/rtdata have no effect.

## Structure
- Op codes `md_mult`…`md_mtlo` go in define.v, next to the existing op/func macros.
- MULT_CYCLES/DIV_CYCLES stay module parameters.
- The decode from op=0/func (mult 0x18, multu 0x19, div 0x1A, divu 0x1B, mthi 0x11, mtlo 0x13) to md_op lives in the controller, not here.
- Optional sub-module md_divider: iterative restoring divider, 32 cycles native, padded or tapped to DIV_CYCLES. It is not required if arithmetic is done at latch time.

## Test plan
- mult 0xFFFFFFFE × 0x00000003 → busy 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA. multu with the same operands → hi=0x00000002, lo=0xFFFFFFFA.
- div −7/2 (0xFFFFFFF9, 0x2) → busy 10 cycles; lo=0xFFFFFFFD, hi=0xFFFFFFFF. divu 7/0 → busy 10 cycles; hi/lo unchanged.
- mthi 0x12345678 then mtlo 0x9ABCDEF0 on consecutive cycles → hi/lo updated after each edge; busy never asserted.
- Issue mult; pulse start with mthi 0xDEADBEEF at cycle 2 of busy → ignored. Final hi/lo are the mult result only; busy length unchanged.
- Assert reset at cycle 3 of a div → busy=0, hi=lo=0 next cycle; no late write at the original completion edge.
- Back-to-back: mult accepted at t0; start at t0+5 (busy=1) ignored; start at t0+6 accepted and restarts the busy window.
